match_count_display: RTL
========================

// Module: match_count_display
// PURPOSE
//  Downstream consumer of the sequence-detector output z. Counts detection events in a BCD counter
//  and drives a time-multiplexed, active-low seven-segment display with the running count.
//  Sits between the detector and the board pins: detector z -> det, an/seg/dp -> pins.
// PARAMETERS
//  DIGITS       4        number of BCD digits / anodes (1..8)
//  REFRESH_DIV  50000    clk cycles each digit stays lit (>=2)
//  SATURATE     1        1: stop at all-9s; 0: wrap to all-0s
//  BLANK_LZ     1        1: blank leading zeros (digit 0 always shown)
// PORTS
//  clk    in   1          system clock, rising edge
//  rst    in   1          synchronous reset, active-low (0 = reset)
//  det    in   1          detector output (z); level, sampled every clk
//  clr    in   1          synchronous count clear, active-high
//  hold   in   1          1 = freeze displayed value; counting continues
//  an     out  DIGITS     digit anodes, active-low, one-hot-low while scanning
//  seg    out  7          segments {g,f,e,d,c,b,a}, active-low
//  dp     out  1          decimal point, active-low; lit on digit 0 when ovf=1
//  ovf    out  1          sticky: count saturated or wrapped
// BEHAVIOUR
//  Reset (rst=0 at edge): count=0, det_q=0, ovf=0, snapshot=0, scan idx=0, refresh cnt=0,
//   an=all 1s, seg=7'h7F, dp=1. Reset mid-scan or mid-count aborts immediately; no partial state kept.
//  Event = det & ~det_q (rising edge); det_q <= det every clk. A det held high counts once.
//  Priority each edge: rst > clr > event. clr clears count and ovf; an event in the clr cycle is dropped.
//  Count: DIGITS-digit BCD, ripple carry inside one clk. Updated at the edge where the event is seen;
//   visible on the count the cycle after.
//  All-9s + event: SATURATE=1 -> count unchanged, ovf<=1. SATURATE=0 -> count=0, ovf<=1.
//  Snapshot: snapshot<=count every clk while hold=0; held while hold=1. Display shows the snapshot only.
//   Releasing hold reloads the snapshot on the next edge.
//  Scan: refresh cnt counts 0..REFRESH_DIV-1; at terminal it goes to 0 and idx <= (idx+1) mod DIGITS.
//   an/seg/dp are registered from idx/snapshot: 1 cycle latency after an idx change.
//   First digit lights 1 cycle after reset release: an=~(1<<0).
//  Decode, active-low: 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
//   Non-BCD values are unreachable; the decoder default is blank 7'h7F.
//  Blanking (BLANK_LZ=1): digit i>0 is blank (seg=7'h7F, anode still driven) when it and all
//   higher digits of the snapshot are 0.
//  dp=0 only when idx==0 and ovf==1; otherwise dp=1.
// STRUCTURE
//  Package match_disp_pkg:
//   - SEG_BLANK and the digit-code localparams
//   - function bcd_to_seg(input [3:0]) -> [6:0]
//  Sub-module bcd_digit:
//   - ports: clk, rst, clr, inc, q[3:0], carry
//   - carry = inc & (q==9); instantiated DIGITS times in a generate loop
//  Top level holds: edge detect, saturation/ovf logic, snapshot, refresh counter, scan mux, output registers.
// TESTING (bench uses REFRESH_DIV=4, DIGITS=4)
//  1 Reset: rst=0 for 3 clks -> an=4'hF, seg=7'h7F, dp=1, ovf=0.
//    After release, 1 clk -> an=4'hE, seg=7'h40.
//  2 Edge counting: det pulses high 1 clk x3, plus det held high 10 clks -> count=4.
//    Digit 0 seg=7'h19; digits 1-3 blank.
//  3 Carry chain: preload by 99 events, then 1 more -> count=0100.
//    Scan shows seg 7'h40, 7'h40, 7'h79 on an=E, D, B; an=7 blank.
//  4 Saturate/wrap: at 9999 apply 1 event.
//    SATURATE=1 -> 9999, ovf=1, dp=0 on an=E.
//    SATURATE=0 -> 0000, ovf=1.
//  5 clr vs event: det edge and clr=1 in the same clk -> count=0, ovf=0.
//    Next det edge -> count=1.
//  6 Hold and reset mid-scan: hold=1 at count=5, then 3 events -> display stays 5, internal count=8.
//    hold=0 -> display 8 within 1+4*4 clks.
//    rst=0 during idx=2 -> next edge an=4'hF.

Source files
------------

// File: rtl/match_disp_pkg.sv
// Shared constants and helpers for the match-count seven-segment display.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package match_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/match_count_display_bcd_digit.sv
// One decade of the event counter: wraps 9 -> 0 on inc and offers a carry
// so decades can be chained combinationally.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_r;

  // decade register; clr outranks inc
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (inc) begin
      q_r <= (q_r == 4'd9) ? 4'd0 : q_r + 4'd1;
    end else begin
      q_r <= q_r;
    end
  end

  assign q     = q_r;
  assign carry = inc & (q_r == 4'd9);

endmodule

// File: rtl/match_count_display.sv
// Counts rising edges of the detector output in BCD and scans the frozen-able
// snapshot of that count onto an active-low multiplexed seven-segment display.
module match_count_display
  import match_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SATURATE    = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              det,
  input  logic              clr,
  input  logic              hold,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              ovf
);

  localparam int   IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   CNT_W  = $clog2(REFRESH_DIV);
  localparam logic SAT_EN = (SATURATE != 0);
  localparam logic LZ_EN  = (BLANK_LZ != 0);

  logic                  det_q_r;
  logic                  ovf_r;
  logic [4*DIGITS-1:0]   snap_r;
  logic [CNT_W-1:0]      ref_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DIGITS-1:0]     an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  logic                  evt_s;
  logic                  all9_s;
  logic                  ovf_set_s;
  logic [4*DIGITS-1:0]   count_s;
  logic [DIGITS:0]       inc_s;
  logic [DIGITS-1:0]     lz_s;
  logic                  lz_hi_s;
  logic [3:0]            digit_s;
  logic                  blank_s;
  logic [DIGITS-1:0]     an_nxt_s;
  logic [6:0]            seg_nxt_s;
  logic                  dp_nxt_s;

  assign evt_s = det & ~det_q_r;

  // In saturate mode the whole chain is frozen at all-9s; in wrap mode the top carry is the wrap.
  assign inc_s[0]  = evt_s & ~clr & ~(SAT_EN & all9_s);
  assign ovf_set_s = SAT_EN ? (evt_s & all9_s) : inc_s[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc_s[g]),
      .q     (count_s[4*g +: 4]),
      .carry (inc_s[g+1])
    );
  end

  // all-nines detect across every decade
  always_comb begin
    all9_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9_s = all9_s & (count_s[4*i +: 4] == 4'd9);
    end
  end

  // edge history, sticky overflow and display snapshot
  always_ff @(posedge clk) begin
    if (!rst) begin
      det_q_r <= 1'b0;
      ovf_r   <= 1'b0;
      snap_r  <= '0;
    end else begin
      det_q_r <= det;
      if (clr) begin
        ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      if (!hold) begin
        snap_r <= count_s;
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  // refresh divider and digit scan index
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_cnt_r <= '0;
      idx_r     <= '0;
    end else if (ref_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
      ref_cnt_r <= '0;
      idx_r     <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
    end else begin
      ref_cnt_r <= ref_cnt_r + CNT_W'(1);
      idx_r     <= idx_r;
    end
  end

  // lz_s[i] is set when snapshot digit i and everything above it are zero
  always_comb begin
    lz_hi_s = 1'b1;
    lz_s    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_hi_s = lz_hi_s & (snap_r[4*i +: 4] == 4'd0);
      lz_s[i] = lz_hi_s;
    end
  end

  // scan mux and decode feeding the output registers
  always_comb begin
    digit_s   = snap_r[4*int'(idx_r) +: 4];
    blank_s   = LZ_EN & (idx_r != IDX_W'(0)) & lz_s[idx_r];
    an_nxt_s  = ~(DIGITS'(1) << idx_r);
    seg_nxt_s = blank_s ? SEG_BLANK : bcd_to_seg(digit_s);
    dp_nxt_s  = ~((idx_r == IDX_W'(0)) & ovf_r);
  end

  // registered pin drivers
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_r  <= '1;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;
  assign ovf = ovf_r;

endmodule
